ultrasonic_ranger_mc: RTL and testbench

//  Multi-channel HC-SR04-style ranging engine; parametrised successor of the single-sensor measurement path.

---
 rtl/ultrasonic_ranger_mc.sv | 244 ++++++++++++++++++++++++
 tb/tb_ultrasonic_ranger_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel HC-SR04-style ranging engine: fires N_CH sensors round-robin and reports echo width in cm.
// Optional ULTRASONIC_BCD_EN adds dist_bcd, a 4-digit BCD copy of the distance.
module ultrasonic_ranger_mc #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned SLOT_US     = 60_000,
    parameter int unsigned TIMEOUT_US  = 30_000,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned DIST_W      = 16,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              sys_clk50m,
    input  logic              sys_rst,
    input  logic              run,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trig,
    output logic [CH_W-1:0]   dist_ch,
    output logic [DIST_W-1:0] dist_data,
    output logic              dist_valid,
    output logic              dist_timeout,
    output logic              busy
`ifdef ULTRASONIC_BCD_EN
    ,
    output logic [15:0]       dist_bcd
`endif
);

    localparam int unsigned US_DIV    = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned TRIG_CLKS = TRIG_US * US_DIV;
    localparam int unsigned DIV_W     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int unsigned SLOT_W    = $clog2(SLOT_US + 1);
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_US + 1);
    localparam int unsigned TRG_W     = $clog2(TRIG_CLKS + 1);
    localparam int unsigned SUB_W     = $clog2(US_PER_CM + 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [N_CH-1:0]   trig_q, trig_d;
    logic [N_CH-1:0]   sync1_q, sync2_q;
    logic              sel_prev_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_us_q, slot_us_d;
    logic [TMO_W-1:0]  tmo_us_q, tmo_us_d;
    logic [TRG_W-1:0]  trig_cnt_q, trig_cnt_d;
    logic [SUB_W-1:0]  sub_us_q, sub_us_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic [CH_W-1:0]   dist_ch_q, dist_ch_d;
    logic [DIST_W-1:0] dist_data_q, dist_data_d;
    logic              dist_valid_q, dist_valid_d;
    logic              dist_timeout_q, dist_timeout_d;
    logic              busy_q, busy_d;

    logic us_tick, sel_now, echo_rise, echo_fall, tmo_hit, slot_done;
    logic start, cm_clr, cm_step, publish;

    assign us_tick   = (div_q == DIV_W'(US_DIV - 1));
    assign sel_now   = sync2_q[ptr_q];
    assign echo_rise = sel_now & ~sel_prev_q;
    assign echo_fall = ~sel_now & sel_prev_q;
    assign tmo_hit   = us_tick && (tmo_us_q == TMO_W'(TIMEOUT_US - 1));
    assign slot_done = us_tick && (slot_us_q >= SLOT_W'(SLOT_US - 1));

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        trig_d         = trig_q;
        div_d          = us_tick ? '0 : div_q + DIV_W'(1);
        slot_us_d      = (us_tick && slot_us_q != SLOT_W'(SLOT_US)) ? slot_us_q + SLOT_W'(1) : slot_us_q;
        tmo_us_d       = (us_tick && tmo_us_q != TMO_W'(TIMEOUT_US)) ? tmo_us_q + TMO_W'(1) : tmo_us_q;
        trig_cnt_d     = trig_cnt_q;
        sub_us_d       = sub_us_q;
        cm_d           = cm_q;
        tmo_flag_d     = tmo_flag_q;
        dist_ch_d      = dist_ch_q;
        dist_data_d    = dist_data_q;
        dist_valid_d   = 1'b0;
        dist_timeout_d = dist_timeout_q;
        start          = 1'b0;
        cm_clr         = 1'b0;
        cm_step        = 1'b0;
        publish        = 1'b0;

        case (state_q)
            IDLE: start = run;
            TRIG: begin
                trig_cnt_d = trig_cnt_q + TRG_W'(1);
                if (trig_cnt_q == TRG_W'(TRIG_CLKS - 1)) begin
                    trig_d   = '0;
                    tmo_us_d = '0;
                    state_d  = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    sub_us_d = '0;
                    cm_clr   = 1'b1;
                    tmo_us_d = '0;
                    state_d  = MEASURE;
                end else if (tmo_hit) begin
                    cm_clr     = 1'b1;
                    tmo_flag_d = 1'b1;
                    state_d    = DONE;
                end
            end
            MEASURE: begin
                // The tick of the exit cycle still counts, so the measured window is exactly the echo width.
                if (us_tick) begin
                    if (sub_us_q == SUB_W'(US_PER_CM - 1)) begin
                        sub_us_d = '0;
                        cm_step  = 1'b1;
                    end else begin
                        sub_us_d = sub_us_q + SUB_W'(1);
                    end
                end
                if (echo_fall) begin
                    tmo_flag_d = 1'b0;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                publish        = 1'b1;
                dist_valid_d   = 1'b1;
                dist_ch_d      = ptr_q;
                dist_data_d    = cm_q;
                dist_timeout_d = tmo_flag_q;
                state_d        = GAP;
            end
            GAP: begin
                if (slot_done) begin
                    ptr_d = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + CH_W'(1);
                    if (run) start = 1'b1;
                    else     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cm_clr)                     cm_d = '0;
        else if (cm_step && cm_q != '1) cm_d = cm_q + DIST_W'(1);

        if (start) begin
            trig_d     = N_CH'(1) << ptr_d;
            div_d      = '0;
            slot_us_d  = '0;
            trig_cnt_d = '0;
            state_d    = TRIG;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk50m) begin
        sync1_q <= echo;
        sync2_q <= sync1_q;
        if (sys_rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            trig_q         <= '0;
            sel_prev_q     <= 1'b0;
            div_q          <= '0;
            slot_us_q      <= '0;
            tmo_us_q       <= '0;
            trig_cnt_q     <= '0;
            sub_us_q       <= '0;
            cm_q           <= '0;
            tmo_flag_q     <= 1'b0;
            dist_ch_q      <= '0;
            dist_data_q    <= '0;
            dist_valid_q   <= 1'b0;
            dist_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            trig_q         <= trig_d;
            sel_prev_q     <= sel_now;
            div_q          <= div_d;
            slot_us_q      <= slot_us_d;
            tmo_us_q       <= tmo_us_d;
            trig_cnt_q     <= trig_cnt_d;
            sub_us_q       <= sub_us_d;
            cm_q           <= cm_d;
            tmo_flag_q     <= tmo_flag_d;
            dist_ch_q      <= dist_ch_d;
            dist_data_q    <= dist_data_d;
            dist_valid_q   <= dist_valid_d;
            dist_timeout_q <= dist_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign trig         = trig_q;
    assign dist_ch      = dist_ch_q;
    assign dist_data    = dist_data_q;
    assign dist_valid   = dist_valid_q;
    assign dist_timeout = dist_timeout_q;
    assign busy         = busy_q;

`ifdef ULTRASONIC_BCD_EN
    logic [15:0] bcd_q, bcd_d, dist_bcd_q, dist_bcd_d;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = (v != 16'h9999);
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        bcd_d      = cm_clr ? '0 : (cm_step ? bcd_inc(bcd_q) : bcd_q);
        dist_bcd_d = publish ? bcd_q : dist_bcd_q;
    end

    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            bcd_q      <= '0;
            dist_bcd_q <= '0;
        end else begin
            bcd_q      <= bcd_d;
            dist_bcd_q <= dist_bcd_d;
        end
    end

    assign dist_bcd = dist_bcd_q;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Bench for ultrasonic_ranger_mc: table of per-slot echo scenarios plus random slots, checked
// against an arithmetic timeline model. Define ULTRASONIC_BCD_EN to also check dist_bcd.
module tb_ultrasonic_ranger_mc;

    localparam int unsigned CLK_HZ = 2_000_000;
    localparam int D         = 2;
    localparam int NCH       = 4;
    localparam int TRIG_US   = 10;
    localparam int SLOT      = 2000;
    localparam int TMO       = 1000;
    localparam int UPC       = 58;
    localparam int DW        = 16;
    localparam int T         = TRIG_US * D;
    localparam int SLOT_CLKS = SLOT * D;

    logic clk = 1'b0;
    logic sys_rst, run;
    logic [NCH-1:0] echo, trig;
    logic [1:0]     dist_ch;
    logic [DW-1:0]  dist_data;
    logic           dist_valid, dist_timeout, busy;
`ifdef ULTRASONIC_BCD_EN
    logic [15:0]    dist_bcd;
`endif

    ultrasonic_ranger_mc #(
        .CLK_FREQ_HZ(CLK_HZ), .N_CH(NCH), .TRIG_US(TRIG_US), .SLOT_US(SLOT),
        .TIMEOUT_US(TMO), .US_PER_CM(UPC), .DIST_W(DW)
    ) dut (
        .sys_clk50m(clk), .sys_rst(sys_rst), .run(run), .echo(echo), .trig(trig),
        .dist_ch(dist_ch), .dist_data(dist_data), .dist_valid(dist_valid),
        .dist_timeout(dist_timeout), .busy(busy)
`ifdef ULTRASONIC_BCD_EN
        , .dist_bcd(dist_bcd)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int prev_t0 = -1;

    typedef struct {
        int ch;
        int rise_us;   // <0: no echo at all
        int width_us;
        bit drop_run;
        int rst_rel;   // >=0: pulse reset this many clocks after trig rise
        int exp_data;
        int exp_tmo;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int rise, input int width,
                                  output int data, output int tmo, output int vrel);
        int r;
        r = T + rise * D;
        if (rise < 0) begin
            data = 0; tmo = 1; vrel = T + TMO * D + 1;
        end else if (width >= TMO) begin
            data = TMO / UPC; tmo = 1;
            vrel = r + D * (3 / D + 1) + (TMO - 1) * D + 1;
        end else begin
            data = width / UPC; tmo = 0; vrel = r + width * D + 4;
        end
        if (data > (1 << DW) - 1) data = (1 << DW) - 1;
    endfunction

    function automatic int to_bcd(input int v);
        int x;
        x = (v > 9999) ? 9999 : v;
        return ((x / 1000) << 12) | (((x / 100) % 10) << 8) | (((x / 10) % 10) << 4) | (x % 10);
    endfunction

    task automatic do_slot(input vec_t v);
        int budget, t0, r, f, seen, vrel_got, ch_got, data_got, tmo_got, bcd_got, shape_err;
        int mdata, mtmo, mrel;
        logic [NCH-1:0] sel, exp_trig;
        budget = SLOT_CLKS + 50;
        seen = 0; vrel_got = -1; ch_got = -1; data_got = -1; tmo_got = -1; bcd_got = -1; shape_err = 0;
        while (trig == '0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("trig_wait", int'(trig != '0), 1);
        if (trig == '0) return;
        t0  = cyc;
        sel = NCH'(1) << v.ch;
        check("trig_ch", trig, sel);
        if (prev_t0 >= 0) check("slot_spacing", t0 - prev_t0, SLOT_CLKS);
        prev_t0 = t0;
        model(v.rise_us, v.width_us, mdata, mtmo, mrel);
        r = T + v.rise_us * D;
        f = r + v.width_us * D;
        for (int rel = 0; rel < SLOT_CLKS - 1; rel++) begin
            if (rel == v.rst_rel) begin
                sys_rst = 1'b1;
                echo    = '0;
                @(posedge clk); #1;
                check("rst_outs", {trig, dist_ch, dist_data, dist_valid, dist_timeout, busy}, 0);
`ifdef ULTRASONIC_BCD_EN
                check("rst_bcd", dist_bcd, 0);
`endif
                sys_rst = 1'b0;
                prev_t0 = -1;
                return;
            end
            exp_trig = (rel < T) ? sel : '0;
            if (trig !== exp_trig) shape_err++;
            if (busy !== 1'b1) shape_err++;
            if (dist_valid === 1'b1) begin
                seen++;
                vrel_got = rel; ch_got = dist_ch; data_got = dist_data; tmo_got = dist_timeout;
`ifdef ULTRASONIC_BCD_EN
                bcd_got = dist_bcd;
`endif
            end
            if (v.drop_run && rel == 100) run = 1'b0;
            echo = (rel < SLOT_CLKS / 2) ? (NCH'($urandom()) & ~sel) : '0;
            if (v.rise_us >= 0 && rel >= r && rel < f) echo = echo | sel;
            @(posedge clk); #1;
        end
        echo = '0;
        check("trig_busy_shape", shape_err, 0);
        check("valid_count", seen, 1);
        check("valid_time", vrel_got, mrel);
        check("dist_ch", ch_got, v.ch);
        check("dist_data", data_got, v.exp_data);
        check("dist_timeout", tmo_got, v.exp_tmo);
        check("model_data", data_got, mdata);
        check("model_tmo", tmo_got, mtmo);
        check("hold_data", dist_data, v.exp_data);
`ifdef ULTRASONIC_BCD_EN
        check("dist_bcd", bcd_got, to_bcd(v.exp_data));
`endif
        if (v.drop_run) begin
            repeat (3) begin @(posedge clk); #1; end
            check("drop_idle", {busy, trig}, 0);
            run = 1'b1;
            prev_t0 = -1;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int d, t, vr, nxt;
        sys_rst = 1'b1; run = 1'b0; echo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {trig, dist_ch, dist_data, dist_valid, dist_timeout, busy}, 0);
        sys_rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_run", {busy, trig}, 0);
        run = 1'b1;

        tbl.push_back('{ch:0, rise_us:100, width_us:580,  drop_run:0, rst_rel:-1, exp_data:10, exp_tmo:0});
        tbl.push_back('{ch:1, rise_us:-1,  width_us:0,    drop_run:0, rst_rel:-1, exp_data:0,  exp_tmo:1});
        tbl.push_back('{ch:2, rise_us:50,  width_us:1500, drop_run:0, rst_rel:-1, exp_data:17, exp_tmo:1});
        tbl.push_back('{ch:3, rise_us:0,   width_us:57,   drop_run:0, rst_rel:-1, exp_data:0,  exp_tmo:0});
        tbl.push_back('{ch:0, rise_us:20,  width_us:999,  drop_run:0, rst_rel:-1, exp_data:17, exp_tmo:0});
        tbl.push_back('{ch:1, rise_us:-1,  width_us:0,    drop_run:0, rst_rel:5,  exp_data:0,  exp_tmo:0});
        tbl.push_back('{ch:0, rise_us:40,  width_us:800,  drop_run:0, rst_rel:T + 40 * D + 200, exp_data:0, exp_tmo:0});
        tbl.push_back('{ch:0, rise_us:10,  width_us:290,  drop_run:1, rst_rel:-1, exp_data:5,  exp_tmo:0});
        tbl.push_back('{ch:1, rise_us:30,  width_us:116,  drop_run:0, rst_rel:-1, exp_data:2,  exp_tmo:0});
        nxt = 2;
        for (int i = 0; i < 3; i++) begin
            v.ch = nxt; v.drop_run = 1'b0; v.rst_rel = -1;
            v.rise_us  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 300));
            v.width_us = int'($urandom_range(1, 1300));
            if (v.width_us >= 995 && v.width_us <= 1005) v.width_us = 1300;
            model(v.rise_us, v.width_us, d, t, vr);
            v.exp_data = d; v.exp_tmo = t;
            tbl.push_back(v);
            nxt = (nxt + 1) % NCH;
        end

        foreach (tbl[i]) do_slot(tbl[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
